// File: rtl/lsu_pkg.sv
// Shared widths and request/response records for the memory-stage load/store unit.
package lsu_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 48;
  localparam int OFF_W  = 12;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
    logic              fault;
  } lsu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              fault;
  } lsu_resp_t;

  function automatic logic [DATA_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction
endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request queue; occupancy kept in a count register one bit wider than the pointers.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lsu_req_t                 din,
  input  logic                     pop,
  output lsu_req_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lsu_req_t         slots [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) slots[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store unit in front of the data memory: EA adder, in-order queue, one op per cycle, registered load response.
// Optional address-range faulting is enabled by defining LSU_ADDR_FAULT_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [DATA_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault,
  output logic              store_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              empty
);
  logic [DATA_W-1:0]    ea;
  logic                 ea_fault;
  lsu_req_t             enq, head;
  logic                 push, pop, load_go;
  logic                 q_full, q_empty;
  logic [$clog2(DEPTH):0] q_count;
  lsu_resp_t            resp_q;

  assign ea = req_base + sext_off(req_offset);

`ifdef LSU_ADDR_FAULT_EN
  // Any bit above the address field set means negative or past the top word.
  assign ea_fault = |ea[DATA_W-1:ADDR_W];
`else
  logic unused_ea_hi;
  assign unused_ea_hi = ^ea[DATA_W-1:ADDR_W];
  assign ea_fault     = 1'b0;
`endif

  assign enq = '{is_store: req_is_store, addr: ea[ADDR_W-1:0], wdata: req_wdata,
                 tag: req_tag, fault: ea_fault};

  assign req_ready = !q_full;
  assign push      = req_valid && !q_full;

  lsu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (enq),
    .pop   (pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // A load at the head stalls everything behind it until the response slot frees.
  always_comb begin
    pop         = 1'b0;
    load_go     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    store_fault = 1'b0;
    if (!rst && !q_empty) begin
      if (head.is_store) begin
        pop         = 1'b1;
        mem_write   = !head.fault;
        store_fault = head.fault;
      end else if (!resp_valid || resp_ready) begin
        pop      = 1'b1;
        load_go  = 1'b1;
        mem_read = !head.fault;
      end
    end
  end

  assign mem_address    = head.addr;
  assign mem_write_data = head.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_q     <= '0;
    end else if (load_go) begin
      resp_valid  <= 1'b1;
      resp_q.data <= head.fault ? '0 : mem_read_data;
      resp_q.tag  <= head.tag;
      resp_q.fault <= head.fault;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_data  = resp_q.data;
  assign resp_tag   = resp_q.tag;
  assign resp_fault = resp_q.fault;
  assign empty      = (q_count == '0) && !resp_valid;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a queue-level reference model compared every cycle.
module tb_mem_stage_lsu;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [47:0] req_base = '0, req_wdata = '0;
  logic [11:0] req_offset = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [47:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_fault, store_fault;
  logic [9:0]  mem_address;
  logic [47:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write, empty;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_fault(resp_fault), .store_fault(store_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .empty(empty)
  );

  // Data memory seen by the DUT
  logic [47:0] dmem [1024];
  assign mem_read_data = dmem[mem_address];
  always @(posedge clk) if (mem_write) dmem[mem_address] <= mem_write_data;

  int total = 0, bad = 0;
  bit chk_en = 0;

  typedef struct {
    bit        st;
    bit [9:0]  addr;
    bit [47:0] wd;
    bit [4:0]  tag;
    bit        f;
  } mreq_t;

  mreq_t     mq[$];
  bit        m_rv;
  bit [47:0] m_rd;
  bit [4:0]  m_rtag;
  bit        m_rf;
  bit [47:0] mmem [1024];

  bit [9:0]  wlog_a[$];
  bit [47:0] wlog_d[$];
  bit [9:0]  rlog[$];
  bit [47:0] plog_d[$];
  bit [4:0]  plog_t[$];
  bit        plog_f[$];
  int        sf_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic mreq_t mk(input bit st, input logic [47:0] b, input logic [11:0] o,
                               input logic [47:0] wd, input logic [4:0] tg);
    mreq_t r;
    logic signed [47:0] e;
    e = $signed(b) + $signed(o);
    r.st = st; r.addr = e[9:0]; r.wd = wd; r.tag = tg;
`ifdef LSU_ADDR_FAULT_EN
    r.f = (e < 0) || (e > 1023);
`else
    r.f = 1'b0;
`endif
    return r;
  endfunction

  function automatic void calc_issue(output bit p, output bit r, output bit w, output bit s);
    p = 0; r = 0; w = 0; s = 0;
    if (!rst && mq.size() > 0) begin
      if (mq[0].st) begin
        p = 1; w = !mq[0].f; s = mq[0].f;
      end else if (!m_rv || resp_ready) begin
        p = 1; r = !mq[0].f;
      end
    end
  endfunction

  // Reference model advances on the same edge as the DUT
  always @(posedge clk) begin
    bit p, r, w, s, ld, can_push;
    if (rst) begin
      mq.delete();
      m_rv = 0; m_rd = '0; m_rtag = '0; m_rf = 0;
    end else begin
      can_push = mq.size() < DEPTH;
      calc_issue(p, r, w, s);
      ld = p && !mq[0].st;
      if (p) begin
        if (w) mmem[mq[0].addr] = mq[0].wd;
        if (ld) begin
          m_rd   = mq[0].f ? 48'd0 : mmem[mq[0].addr];
          m_rtag = mq[0].tag;
          m_rf   = mq[0].f;
        end
        void'(mq.pop_front());
      end
      if (ld) m_rv = 1;
      else if (resp_ready) m_rv = 0;
      if (req_valid && can_push)
        mq.push_back(mk(req_is_store, req_base, req_offset, req_wdata, req_tag));
    end
  end

  always @(negedge clk) begin
    bit p, r, w, s;
    if (chk_en) begin
      calc_issue(p, r, w, s);
      chk("req_ready", req_ready, mq.size() < DEPTH);
      chk("empty", empty, (mq.size() == 0) && !m_rv);
      chk("mem_read", mem_read, r);
      chk("mem_write", mem_write, w);
      chk("store_fault", store_fault, s);
      if (r || w) chk("mem_address", mem_address, mq[0].addr);
      if (w) chk("mem_write_data", mem_write_data, mq[0].wd);
      chk("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        chk("resp_data", resp_data, m_rd);
        chk("resp_tag", resp_tag, m_rtag);
        chk("resp_fault", resp_fault, m_rf);
      end
      if (mem_write) begin wlog_a.push_back(mem_address); wlog_d.push_back(mem_write_data); end
      if (mem_read) rlog.push_back(mem_address);
      if (resp_valid && resp_ready) begin
        plog_d.push_back(resp_data); plog_t.push_back(resp_tag); plog_f.push_back(resp_fault);
      end
      if (store_fault) sf_cnt++;
    end
  end

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); rlog.delete();
    plog_d.delete(); plog_t.delete(); plog_f.delete();
    sf_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input bit st, input logic [47:0] b, input logic [11:0] o,
                      input logic [47:0] wd, input logic [4:0] tg);
    int n = 0;
    req_valid = 1; req_is_store = st; req_base = b; req_offset = o; req_wdata = wd; req_tag = tg;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL send_timeout actual=req_ready_low required=accept t=%0t", $time);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 48'(i * 7 + 5);
      mmem[i] = 48'(i * 7 + 5);
    end
    clear_logs();
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    @(posedge clk); #1;

    // Store then dependent load through the same address
    clear_logs();
    send(1, 48'h10, 12'd2, 48'd123, 5'd0);
    send(0, 48'h13, 12'hFFF, 48'd0, 5'd7);
    idle(4);
    chk("st_ld_wcount", wlog_a.size(), 1);
    chk("st_ld_waddr", wlog_a[0], 10'h12);
    chk("st_ld_wdata", wlog_d[0], 48'd123);
    chk("st_ld_rcount", rlog.size(), 1);
    chk("st_ld_raddr", rlog[0], 10'h12);
    chk("st_ld_pcount", plog_d.size(), 1);
    chk("st_ld_rdata", plog_d[0], 48'd123);
    chk("st_ld_rtag", plog_t[0], 5'd7);

    // Back-pressure: one response held plus a full queue
    clear_logs();
    resp_ready = 0;
    for (int i = 0; i < 5; i++) send(0, 48'h20, 12'(i), 48'd0, 5'(i + 1));
    @(negedge clk);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_resp_valid", resp_valid, 1);
    chk("bp_resp_tag", resp_tag, 5'd1);
    chk("bp_resp_data", resp_data, 48'd229);
    repeat (2) @(negedge clk);
    chk("bp_hold_data", resp_data, 48'd229);
    @(posedge clk); #1 resp_ready = 1;
    idle(8);
    chk("bp_pcount", plog_d.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_order_tag", plog_t[i], 5'(i + 1));
      chk("bp_order_data", plog_d[i], 48'(229 + 7 * i));
    end

    // Load past the top of memory
    clear_logs();
    send(0, 48'd1023, 12'd1, 48'd0, 5'd9);
    idle(4);
    chk("wrap_pcount", plog_d.size(), 1);
    chk("wrap_tag", plog_t[0], 5'd9);
`ifdef LSU_ADDR_FAULT_EN
    chk("wrap_rcount", rlog.size(), 0);
    chk("wrap_fault", plog_f[0], 1);
    chk("wrap_data", plog_d[0], 48'd0);
`else
    chk("wrap_rcount", rlog.size(), 1);
    chk("wrap_raddr", rlog[0], 10'd0);
    chk("wrap_data", plog_d[0], 48'd5);
    chk("wrap_fault", plog_f[0], 0);
`endif

    // Store with a negative effective address
    clear_logs();
    send(1, 48'd5, 12'hFFA, 48'hABC, 5'd0);
    idle(3);
`ifdef LSU_ADDR_FAULT_EN
    chk("neg_wcount", wlog_a.size(), 0);
    chk("neg_sfault", sf_cnt, 1);
`else
    chk("neg_wcount", wlog_a.size(), 1);
    chk("neg_waddr", wlog_a[0], 10'h3FF);
    chk("neg_wdata", wlog_d[0], 48'hABC);
    chk("neg_sfault", sf_cnt, 0);
`endif

    // Reset with queued work and a held response
    resp_ready = 0;
    for (int i = 0; i < 4; i++) send(0, 48'h30, 12'(i), 48'd0, 5'(11 + i));
    @(negedge clk);
    chk("mid_resp_valid", resp_valid, 1);
    chk("mid_empty", empty, 0);
    @(posedge clk); #1;
    rst = 1; resp_ready = 1;
    @(negedge clk);
    chk("rstcyc_mem_read", mem_read, 0);
    chk("rstcyc_mem_write", mem_write, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_empty", empty, 1);
    chk("post_req_ready", req_ready, 1);
    chk("post_resp_data", resp_data, 0);
    chk("post_resp_tag", resp_tag, 0);
    chk("post_mem_read", mem_read, 0);
    @(posedge clk); #1;

    // Mixed back-to-back stream at full rate
    clear_logs();
    send(1, 48'h100, 12'd0, 48'h111, 5'd0);
    send(0, 48'h100, 12'd0, 48'd0, 5'd2);
    send(1, 48'h101, 12'd0, 48'h222, 5'd0);
    send(0, 48'h102, 12'hFFF, 48'd0, 5'd3);
    send(0, 48'h0FF, 12'd1, 48'd0, 5'd4);
    idle(6);
    chk("mix_pcount", plog_d.size(), 3);
    chk("mix_d0", plog_d[0], 48'h111);
    chk("mix_d1", plog_d[1], 48'h222);
    chk("mix_d2", plog_d[2], 48'h111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
